// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: demuxes the ioctl download stream into ROM writes, game select
// and DIP bytes, and sequences core reset including the delayed second pulse
// that follows a completed ROM load.
module rom_load_ctrl #(
  parameter int unsigned SECOND_RESET_CYCLES = 40000000,
  parameter int unsigned ROM_AW              = 16,
  parameter int unsigned MOD_INDEX           = 1,
  parameter int unsigned DIP_INDEX           = 254,
  parameter int unsigned NUM_MODS            = 6
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic                user_reset,
  output logic                rom_we,
  output logic [ROM_AW-1:0]   rom_addr,
  output logic [7:0]          rom_data,
  output logic                rom_downloading,
  output logic                rom_loaded,
  output logic                rom_overflow,
  output logic [NUM_MODS-1:0] mod_onehot,
  output logic [63:0]         dip_sw,
  output logic                core_reset
);

  localparam int unsigned CW = $clog2(SECOND_RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ARM  = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic                is_rom_c;
  logic                rom_in_range_c;
  logic                is_mod_c;
  logic                is_dip_c;
  logic [NUM_MODS-1:0] mod_dec_c;

  // Stream classification for the current ioctl beat
  always_comb begin
    is_rom_c       = ioctl_wr && ioctl_download && (ioctl_index == 8'd0);
    rom_in_range_c = ((ioctl_addr >> ROM_AW) == 25'd0);
    is_mod_c       = ioctl_wr && (ioctl_index == 8'(MOD_INDEX));
    is_dip_c       = ioctl_wr && (ioctl_index == 8'(DIP_INDEX)) && (ioctl_addr[24:3] == 22'd0);
  end

  // Game-select decode: bit n set when the byte equals n, none when out of range
  always_comb begin
    mod_dec_c = '0;
    for (int i = 0; i < int'(NUM_MODS); i++) begin
      if (ioctl_dout == 8'(i)) mod_dec_c[i] = 1'b1;
    end
  end

  // Registered ROM write port, overflow flag, game select and DIP bytes
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_we          <= 1'b0;
      rom_addr        <= '0;
      rom_data        <= 8'd0;
      rom_downloading <= 1'b0;
      rom_overflow    <= 1'b0;
      mod_onehot      <= NUM_MODS'(1);
      dip_sw          <= 64'd0;
    end else begin
      rom_downloading <= ioctl_download && (ioctl_index == 8'd0);
      rom_we          <= is_rom_c && rom_in_range_c;
      if (is_rom_c && rom_in_range_c) begin
        rom_addr <= ioctl_addr[ROM_AW-1:0];
        rom_data <= ioctl_dout;
      end
      if (is_rom_c && !rom_in_range_c) rom_overflow <= 1'b1;
      if (is_mod_c) mod_onehot <= mod_dec_c;
      if (is_dip_c) dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

  // Load/arm sequencing and registered core reset
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rom_loaded <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      core_reset <= user_reset || (state == IDLE) || (state == LOAD) ||
                    ((state == ARM) && (cnt == CW'(1)));
      case (state)
        IDLE: if (rom_downloading) state <= LOAD;
        LOAD: begin
          if (!rom_downloading) begin
            state      <= ARM;
            rom_loaded <= 1'b1;
            cnt        <= CW'(SECOND_RESET_CYCLES);
          end
        end
        ARM: begin
          cnt <= cnt - CW'(1);
          if (rom_downloading)       state <= LOAD;
          else if (cnt == CW'(1))    state <= RUN;
        end
        RUN: if (rom_downloading) state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Randomized bench for rom_load_ctrl against a history-based reference model.
module tb_rom_load_ctrl;

  localparam int N = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl = 1'b0;
  logic [7:0]  idx = 8'd0;
  logic        wr = 1'b0;
  logic [24:0] addr = 25'd0;
  logic [7:0]  dout = 8'd0;
  logic        user = 1'b0;

  logic        rom_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_downloading;
  logic        rom_loaded;
  logic        rom_overflow;
  logic [5:0]  mod_onehot;
  logic [63:0] dip_sw;
  logic        core_reset;

  rom_load_ctrl #(
    .SECOND_RESET_CYCLES(N), .ROM_AW(16), .MOD_INDEX(1), .DIP_INDEX(254), .NUM_MODS(6)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(dl), .ioctl_index(idx),
    .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .user_reset(user),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_downloading(rom_downloading), .rom_loaded(rom_loaded),
    .rom_overflow(rom_overflow), .mod_onehot(mod_onehot), .dip_sw(dip_sw),
    .core_reset(core_reset)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;
  bit rand_user = 1'b0;

  // Reference model: expectations derived from the history of the registered
  // download flag (last edge it was high) rather than from a state machine.
  int          e = 0;
  int          lo1 = -1, lo2 = -1;
  bit          rd1 = 1'b0, rd2 = 1'b0;
  bit          m_we, m_dl, m_loaded, m_ovf, m_core;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  logic [5:0]  m_mod;
  logic [7:0]  m_dip [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] dip_pack();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = m_dip[k];
    return v;
  endfunction

  task automatic model_reset();
    m_we = 0; m_addr = 0; m_data = 0; m_dl = 0; m_loaded = 0; m_ovf = 0;
    m_core = 1; m_mod = 6'b000001;
    for (int k = 0; k < 8; k++) m_dip[k] = 8'd0;
    rd1 = 0; rd2 = 0; lo1 = -1; lo2 = -1;
  endtask

  task automatic model_edge();
    bit rom_ok, new_rd;
    e++;
    rom_ok = wr && dl && (idx == 8'd0);
    m_we = rom_ok && (addr < 25'h10000);
    if (m_we) begin
      m_addr = addr[15:0];
      m_data = dout;
    end
    if (rom_ok && addr >= 25'h10000) m_ovf = 1;
    if (wr && idx == 8'd1) m_mod = (dout < 8'd6) ? 6'(1 << dout) : 6'd0;
    if (wr && idx == 8'd254 && addr < 25'd8) m_dip[addr[2:0]] = dout;
    // Reset held while no ROM yet or loading; one extra cycle N+1 edges after the last loading edge
    m_core = user || (lo2 < 0) || rd2 || ((lo2 >= 0) && (e - 1 == lo2 + N + 1));
    if (!rd1 && rd2) m_loaded = 1;
    new_rd = dl && (idx == 8'd0);
    rd2 = rd1; lo2 = lo1;
    rd1 = new_rd;
    if (new_rd) lo1 = e;
    m_dl = new_rd;
  endtask

  task automatic compare_all();
    check("rom_we", 64'(rom_we), 64'(m_we));
    if (m_we) begin
      check("rom_addr", 64'(rom_addr), 64'(m_addr));
      check("rom_data", 64'(rom_data), 64'(m_data));
    end
    check("rom_downloading", 64'(rom_downloading), 64'(m_dl));
    check("rom_loaded", 64'(rom_loaded), 64'(m_loaded));
    check("rom_overflow", 64'(rom_overflow), 64'(m_ovf));
    check("mod_onehot", 64'(mod_onehot), 64'(m_mod));
    check("dip_sw", dip_sw, dip_pack());
    check("core_reset", 64'(core_reset), 64'(m_core));
  endtask

  task automatic tick();
    if (rand_user) user = ($urandom_range(0, 19) == 0);
    @(posedge clk_sys);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    wr = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wbyte(input logic [24:0] a, input logic [7:0] d, input int gap);
    wr = 1; addr = a; dout = d;
    tick();
    wr = 0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  logic [7:0] t2_data [4];
  int         hi_cnt;

  initial begin
    t2_data[0] = 8'hA5; t2_data[1] = 8'h5A; t2_data[2] = 8'hFF; t2_data[3] = 8'h00;
    model_reset();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    idle(3);

    // T1: reset asserted in the middle of a ROM stream
    dl = 1; idx = 8'd0;
    tick();
    wbyte(25'd7, 8'h11, 0);
    wbyte(25'd8, 8'h22, 1);
    idle(N + 4);
    wr = 1; addr = 25'd9; dout = 8'h33;
    reset_n = 0;
    tick();
    check("t1_core_reset", 64'(core_reset), 64'd1);
    check("t1_rom_we", 64'(rom_we), 64'd0);
    check("t1_loaded", 64'(rom_loaded), 64'd0);
    wr = 0; dl = 0;
    tick();
    reset_n = 1;
    idle(4);

    // T2: four ROM bytes back to back
    dl = 1; idx = 8'd0;
    tick();
    for (int i = 0; i < 4; i++) wbyte(25'(i), t2_data[i], 0);
    dl = 0;
    // T3: watch the delayed second pulse
    hi_cnt = 0;
    for (int i = 0; i < N + 6; i++) begin
      tick();
      if (core_reset) hi_cnt++;
    end
    check("t3_high_cycles", 64'(hi_cnt), 64'd3);
    check("t2_loaded", 64'(rom_loaded), 64'd1);

    // T4: out-of-range ROM byte
    dl = 1; idx = 8'd0;
    tick();
    wbyte(25'h10000, 8'h77, 1);
    check("t4_overflow", 64'(rom_overflow), 64'd1);
    dl = 0;
    idle(N + 4);
    check("t4_sticky", 64'(rom_overflow), 64'd1);

    // T5: game select and DIP bytes
    dl = 1; idx = 8'd1;
    wbyte(25'd0, 8'd4, 1);
    check("t5_mod4", 64'(mod_onehot), 64'h10);
    wbyte(25'd0, 8'd7, 1);
    check("t5_mod7", 64'(mod_onehot), 64'h0);
    idx = 8'd254;
    wbyte(25'd1, 8'h3C, 1);
    wbyte(25'd8, 8'hEE, 1);
    check("t5_dip1", 64'(dip_sw[15:8]), 64'h3C);
    dl = 0;
    idle(2);

    // T6: reload while armed, then user reset pulses in RUN
    dl = 1; idx = 8'd0;
    tick();
    wbyte(25'd100, 8'h42, 0);
    dl = 0;
    idle(9);
    dl = 1;
    wbyte(25'd101, 8'h43, 2);
    dl = 0;
    idle(N + 6);
    user = 1; tick(); user = 0;
    idle(3);

    // Randomized sessions with random user reset and occasional async reset
    rand_user = 1;
    for (int s = 0; s < 60; s++) begin
      int sel, nw;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1: idx = 8'd0;
        2:    idx = 8'd1;
        3:    idx = 8'd254;
        default: idx = 8'($urandom_range(2, 253));
      endcase
      dl = 1;
      tick();
      nw = int'($urandom_range(1, 6));
      for (int w = 0; w < nw; w++) begin
        logic [24:0] a;
        if (idx == 8'd254) a = 25'($urandom_range(0, 15));
        else if ($urandom_range(0, 7) == 0) a = 25'($urandom_range(16'hFFFF, 25'h1FFFFFF));
        else a = 25'($urandom_range(0, 16'hFFFF));
        wbyte(a, 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      end
      dl = 0;
      idle(int'($urandom_range(0, N + 6)));
      if ($urandom_range(0, 9) == 0) begin
        reset_n = 0;
        tick();
        reset_n = 1;
      end
    end
    rand_user = 0;
    user = 0;
    idle(N + 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
